// File: rtl/fault_injection_ctrl.sv
// Fault-injection campaign controller: loads a per-flop mask over a valid/ready
// word stream, then gates it onto injection_vector from an LFSR-vs-threshold test.
module fault_injection_ctrl #(
  parameter int unsigned NUM_INJ  = 216,
  parameter logic [31:0] DEF_SEED = 32'hACE1_2345
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_data,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        duration,
  input  logic [31:0]        threshold,
  input  logic [31:0]        seed,
  output logic [NUM_INJ-1:0] injection_vector,
  output logic               busy,
  output logic               done,
  output logic [15:0]        inj_count
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NW        = (NUM_INJ + WORD_W - 1) / WORD_W;
  localparam int unsigned IDX_W     = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned CNT_W     = 16;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} stateT;

  stateT              state, stateNext;
  logic [NUM_INJ-1:0] mask, maskNext;
  logic               maskValid, maskValidNext;
  logic [IDX_W-1:0]   wordIdx, wordIdxNext;
  logic [31:0]        cycleCnt, cycleCntNext;
  logic [31:0]        thrReg, thrRegNext;
  logic [31:0]        lfsr, lfsrNext, lfsrStep;
  logic [NUM_INJ-1:0] injVecNext;
  logic [CNT_W-1:0]   injCountNext;
  logic               busyNext, doneNext, cfgReadyNext;
  logic               cfgFire, wrEn;
  logic [IDX_W-1:0]   wrIdx;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      mask             <= '0;
      maskValid        <= 1'b0;
      wordIdx          <= '0;
      cycleCnt         <= '0;
      thrReg           <= '0;
      lfsr             <= DEF_SEED;
      injection_vector <= '0;
      inj_count        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_ready        <= 1'b1;
    end else begin
      state            <= stateNext;
      mask             <= maskNext;
      maskValid        <= maskValidNext;
      wordIdx          <= wordIdxNext;
      cycleCnt         <= cycleCntNext;
      thrReg           <= thrRegNext;
      lfsr             <= lfsrNext;
      injection_vector <= injVecNext;
      inj_count        <= injCountNext;
      busy             <= busyNext;
      done             <= doneNext;
      cfg_ready        <= cfgReadyNext;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    stateNext     = state;
    maskNext      = mask;
    maskValidNext = maskValid;
    wordIdxNext   = wordIdx;
    cycleCntNext  = cycleCnt;
    thrRegNext    = thrReg;
    lfsrNext      = lfsr;
    injVecNext    = '0;
    injCountNext  = inj_count;
    wrEn          = 1'b0;
    wrIdx         = wordIdx;
    cfgFire       = cfg_valid && cfg_ready;
    lfsrStep      = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

    case (state)
      IDLE: begin
        if (cfgFire) begin
          // A new word 0 always restarts the mask load
          wrEn  = 1'b1;
          wrIdx = '0;
          if (NW == 1) begin
            maskValidNext = 1'b1;
          end else begin
            maskValidNext = 1'b0;
            wordIdxNext   = IDX_W'(1);
            stateNext     = LOAD;
          end
        end else if (start && maskValid) begin
          cycleCntNext = duration;
          thrRegNext   = threshold;
          lfsrNext     = (seed == 32'd0) ? DEF_SEED : seed;
          injCountNext = '0;
          stateNext    = (duration == 32'd0) ? DONE : RUN;
        end
      end
      LOAD: begin
        if (cfgFire) begin
          wrEn = 1'b1;
          if (wordIdx == LAST_IDX) begin
            maskValidNext = 1'b1;
            wordIdxNext   = '0;
            stateNext     = IDLE;
          end else begin
            wordIdxNext = wordIdx + IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (abort) begin
          stateNext = IDLE;
        end else begin
          lfsrNext     = lfsrStep;
          cycleCntNext = cycleCnt - 32'd1;
          if (lfsr < thrReg) begin
            injVecNext = mask;
            if (inj_count != '1) injCountNext = inj_count + CNT_W'(1);
          end
          if (cycleCnt == 32'd1) stateNext = DONE;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Bits at or above NUM_INJ in the last word are dropped
    if (wrEn) begin
      for (int unsigned i = 0; i < NUM_INJ; i++) begin
        if ((i >> 5) == 32'(wrIdx)) maskNext[i] = cfg_data[i[4:0]];
      end
    end

    busyNext     = (stateNext == RUN);
    doneNext     = (stateNext == DONE);
    cfgReadyNext = (stateNext == IDLE) || (stateNext == LOAD);
  end

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Self-checking bench for fault_injection_ctrl: scoreboard of expected
// injection vectors built from an independent LFSR/threshold model.
module tb_fault_injection_ctrl;

  localparam int unsigned NUM_INJ  = 216;
  localparam logic [31:0] DEF_SEED = 32'hACE1_2345;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_data;
  logic               start;
  logic               abort;
  logic [31:0]        duration;
  logic [31:0]        threshold;
  logic [31:0]        seed;
  logic [NUM_INJ-1:0] injection_vector;
  logic               busy;
  logic               done;
  logic [15:0]        inj_count;

  int testsRun;
  int testsFailed;

  logic [223:0]       loadImage;
  logic [NUM_INJ-1:0] expMask;
  logic [31:0]        words [7];
  logic [NUM_INJ-1:0] sbQ [$];

  fault_injection_ctrl #(.NUM_INJ(NUM_INJ), .DEF_SEED(DEF_SEED)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .start(start), .abort(abort),
    .duration(duration), .threshold(threshold), .seed(seed),
    .injection_vector(injection_vector), .busy(busy), .done(done),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_words(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[k];
      testsRun++;
      if (cfg_ready !== 1'b1) begin
        testsFailed++;
        $display("FAIL cfg_ready_load word%0d: got %b want 1", k, cfg_ready);
      end
      loadImage[32*k +: 32] = words[k];
      tick();
    end
    cfg_valid = 1'b0;
    expMask   = loadImage[NUM_INJ-1:0];
  endtask

  task automatic run_campaign(input logic [31:0] dur, input logic [31:0] thr,
                              input logic [31:0] sd, input int abortAt, input string name);
    logic [31:0]        l;
    logic [15:0]        expCount;
    logic [NUM_INJ-1:0] exp;
    l        = (sd == 32'd0) ? DEF_SEED : sd;
    expCount = 16'd0;
    start = 1'b1; duration = dur; threshold = thr; seed = sd;
    tick();
    start = 1'b0;
    testsRun++;
    if (injection_vector !== '0) begin
      testsFailed++;
      $display("FAIL %s vec_after_start: got %h want 0", name, injection_vector);
    end
    if (dur == 32'd0) begin
      testsRun++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        testsFailed++;
        $display("FAIL %s zero_dur_done: got done=%b busy=%b want done=1 busy=0", name, done, busy);
      end
      tick();
      testsRun++;
      if (done !== 1'b0 || inj_count !== 16'd0) begin
        testsFailed++;
        $display("FAIL %s zero_dur_end: got done=%b cnt=%0d want done=0 cnt=0", name, done, inj_count);
      end
      return;
    end
    for (int c = 1; c <= int'(dur); c++) begin
      testsRun++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        testsFailed++;
        $display("FAIL %s run_cycle%0d: got busy=%b done=%b want busy=1 done=0", name, c, busy, done);
      end
      if (c == abortAt) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || injection_vector !== '0 ||
            cfg_ready !== 1'b1 || inj_count !== expCount) begin
          testsFailed++;
          $display("FAIL %s abort: got busy=%b done=%b vec=%h rdy=%b cnt=%0d want 0 0 0 1 %0d",
                   name, busy, done, injection_vector, cfg_ready, inj_count, expCount);
        end
        tick();
        testsRun++;
        if (done !== 1'b0 || busy !== 1'b0 || injection_vector !== '0) begin
          testsFailed++;
          $display("FAIL %s post_abort: got done=%b busy=%b vec=%h want 0 0 0", name, done, busy, injection_vector);
        end
        return;
      end
      sbQ.push_back((l < thr) ? expMask : '0);
      if (l < thr) expCount++;
      l = lfsr_step(l);
      tick();
      exp = sbQ.pop_front();
      testsRun++;
      if (injection_vector !== exp) begin
        testsFailed++;
        $display("FAIL %s vec_cycle%0d: got %h want %h", name, c, injection_vector, exp);
      end
    end
    testsRun++;
    if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s done_state: got done=%b busy=%b rdy=%b want 1 0 0", name, done, busy, cfg_ready);
    end
    tick();
    testsRun++;
    if (done !== 1'b0 || injection_vector !== '0 || inj_count !== expCount || cfg_ready !== 1'b1) begin
      testsFailed++;
      $display("FAIL %s end: got done=%b vec=%h cnt=%0d rdy=%b want 0 0 %0d 1",
               name, done, injection_vector, inj_count, cfg_ready, expCount);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (injection_vector !== '0 || busy !== 1'b0 || done !== 1'b0 || inj_count !== 16'd0) begin
      testsFailed++;
      $display("FAIL reset_outputs: got vec=%h busy=%b done=%b cnt=%0d want all 0",
               injection_vector, busy, done, inj_count);
    end
    rst = 1'b1;
    start = 1'b1; duration = 32'd5; threshold = '1;
    tick();
    start = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      testsFailed++;
      $display("FAIL reset_start_no_mask: got busy=%b done=%b rdy=%b want 0 0 1", busy, done, cfg_ready);
    end
  endtask

  task automatic test_full_inject();
    for (int k = 0; k < 7; k++) words[k] = 32'hFFFF_FFFF;
    send_words(0, 6);
    run_campaign(32'd10, 32'hFFFF_FFFF, 32'd0, 0, "full_inject");
  endtask

  task automatic test_threshold_zero();
    run_campaign(32'd100, 32'd0, 32'h1234_5678, 0, "thr_zero");
  endtask

  task automatic test_partial_load();
    words[0] = 32'h0123_4567; words[1] = 32'h89AB_CDEF; words[2] = 32'hA5A5_5A5A;
    words[3] = 32'h0F0F_F0F0; words[4] = 32'h1357_9BDF; words[5] = 32'h8000_0001;
    words[6] = 32'hDEAD_BEEF;
    send_words(0, 2);
    start = 1'b1; duration = 32'd20; threshold = '1; seed = 32'd0;
    tick();
    start = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      testsFailed++;
      $display("FAIL partial_start_ignored: got busy=%b rdy=%b want 0 1", busy, cfg_ready);
    end
    send_words(3, 6);
    run_campaign(32'd20, 32'h8000_0000, 32'hDEAD_BEEF, 0, "partial_then_full");
  endtask

  task automatic test_abort();
    run_campaign(32'd50, 32'h8000_0000, 32'h0BAD_F00D, 5, "abort_c5");
  endtask

  task automatic test_abort_on_expiry();
    run_campaign(32'd3, 32'hC000_0000, 32'h7777_1111, 3, "abort_expiry");
  endtask

  task automatic test_duration_zero();
    run_campaign(32'd0, 32'hFFFF_FFFF, 32'h5555_AAAA, 0, "dur_zero");
  endtask

  task automatic test_back_to_back();
    run_campaign(32'd7, 32'h4000_0000, 32'h1357_9BDF, 0, "b2b_first");
    run_campaign(32'd12, 32'hC000_0000, 32'd0, 0, "b2b_second");
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 7; k++) words[k] = 32'hFFFF_FFFF;
    send_words(0, 6);
    start = 1'b1; duration = 32'd50; threshold = '1; seed = 32'd1;
    tick();
    start = 1'b0;
    tick();
    testsRun++;
    if (injection_vector !== expMask) begin
      testsFailed++;
      $display("FAIL midrun_inject_active: got %h want %h", injection_vector, expMask);
    end
    #2 rst = 1'b0;
    #1;
    testsRun++;
    if (injection_vector !== '0 || busy !== 1'b0 || inj_count !== 16'd0) begin
      testsFailed++;
      $display("FAIL midrun_async_clear: got vec=%h busy=%b cnt=%0d want 0 0 0",
               injection_vector, busy, inj_count);
    end
    loadImage = '0;
    expMask   = '0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1; duration = 32'd5;
    tick();
    start = 1'b0;
    tick();
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("FAIL midrun_start_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
    send_words(0, 6);
    run_campaign(32'd5, 32'hFFFF_FFFF, 32'd1, 0, "after_reload");
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0; abort = 1'b0;
    duration = '0; threshold = '0; seed = '0;
    testsRun = 0; testsFailed = 0;
    loadImage = '0; expMask = '0;
    test_reset();
    test_full_inject();
    test_threshold_zero();
    test_partial_load();
    test_abort();
    test_abort_on_expiry();
    test_duration_zero();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fault_injection_ctrl.md
FAULT_INJECTION_CTRL -- requirements
Module: fault_injection_ctrl

Interface
REQ-001 SHALL have parameter NUM_INJ, default 216: width of the injection vector driven into circuit_under_test.
REQ-002 SHALL have parameter DEF_SEED, default 32'hACE1_2345: LFSR seed used when seed input is zero.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  in  1  mask word offered.
REQ-006 SHALL have port cfg_ready  out  1  mask word accepted when high with cfg_valid.
REQ-007 SHALL have port cfg_data  in  32  mask word.
REQ-008 SHALL have port start  in  1  begin campaign.
REQ-009 SHALL have port abort  in  1  terminate campaign.
REQ-010 SHALL have port duration  in  32  campaign length in cycles, sampled at start.
REQ-011 SHALL have port threshold  in  32  injection probability, sampled at start.
REQ-012 SHALL have port seed  in  32  LFSR seed, sampled at start.
REQ-013 SHALL have port injection_vector  out  NUM_INJ  registered per-flop fault enables.
REQ-014 SHALL have port busy  out  1  high in RUN.
REQ-015 SHALL have port done  out  1  one-cycle pulse at campaign end.
REQ-016 SHALL have port inj_count  out  16  number of injection cycles in last campaign.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-018 SHALL hold NW = ceil(NUM_INJ/32) mask words; word k fills mask bits [32k+31:32k]; bits at or above NUM_INJ discarded.
REQ-019 SHALL assert cfg_ready in IDLE and LOAD only; deasserted in RUN and DONE.
REQ-020 SHALL, on a cfg handshake in IDLE, store word 0, clear mask_valid, enter LOAD (or return to IDLE with mask_valid=1 if NW=1).
REQ-021 SHALL, in LOAD, store each handshaken word at the next index; after word NW-1, set mask_valid=1 and enter IDLE.
REQ-022 SHALL ignore start in LOAD, and in IDLE while mask_valid=0.
REQ-023 SHALL, on start in IDLE with mask_valid=1: load cycle counter from duration, threshold register, LFSR from seed (DEF_SEED if seed=0), clear inj_count, enter RUN; duration=0 enters DONE directly with no injection.
REQ-024 SHALL use a 32-bit Galois LFSR, taps 32'h8020_0003, advancing once per RUN cycle; state never zero.
REQ-025 SHALL, each RUN cycle, drive injection_vector = mask on the next edge if current LFSR value < threshold (unsigned, strict), else all-zero.
REQ-026 SHALL never inject with threshold=0.
REQ-027 SHALL increment inj_count per injecting cycle, saturating at 16'hFFFF.
REQ-028 SHALL decrement the cycle counter each RUN cycle and enter DONE after exactly duration RUN cycles.
REQ-029 SHALL, in DONE, drive injection_vector to zero, pulse done for one cycle, and return to IDLE; mask retained.
REQ-030 SHALL, on abort in RUN, enter IDLE next cycle with injection_vector zero, no done pulse, inj_count frozen; abort elsewhere ignored.
REQ-031 SHALL give abort priority over counter expiry when both occur in the same cycle.
REQ-032 SHALL drive injection_vector zero in all states except the cycle following an injecting RUN cycle.

Reset
REQ-033 SHALL, while rst=0, force IDLE, mask all-zero, mask_valid=0, word index 0, injection_vector 0, busy 0, done 0, inj_count 0, LFSR DEF_SEED.
REQ-034 SHALL, on reset mid-RUN, clear injection_vector asynchronously without waiting for clk.

Verification
REQ-035 SHALL cover: load 7 words of 32'hFFFF_FFFF, start with duration=10, threshold=32'hFFFF_FFFF -> busy 10 cycles, injection_vector = 216 ones on each injecting cycle, inj_count=10 (or 9 if LFSR hits all-ones), done pulse once.
REQ-036 SHALL cover: threshold=0, duration=100 -> injection_vector stays 0, inj_count=0, done after 100 cycles.
REQ-037 SHALL cover: start before mask fully loaded (3 of 7 words) -> ignored, busy stays 0; after word 7, start accepted.
REQ-038 SHALL cover: abort on cycle 5 of duration=50 -> IDLE next cycle, no done, injection_vector 0, cfg_ready 1.
REQ-039 SHALL cover: duration=0 -> no RUN cycles, done pulses one cycle after start, inj_count=0.
REQ-040 SHALL cover: rst low mid-RUN with injection active -> injection_vector 0 immediately; after release, start ignored until mask reloaded.
